// File: rtl/alu_issue_sequencer.sv
// Issue sequencer in front of the 32-bit ALU: accepts an instruction word, reads the operands,
// drives the ALU for one cycle, then writes the result back or resolves the branch.
module alu_issue_sequencer #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [31:0]        instr,
   output logic [RADDR_W-1:0] rf_raddr1,
   output logic [RADDR_W-1:0] rf_raddr2,
   input  logic [DATA_W-1:0]  rf_rdata1,
   input  logic [DATA_W-1:0]  rf_rdata2,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic [DATA_W-1:0]  alu_inp1,
   output logic [DATA_W-1:0]  alu_inp2,
   output logic [3:0]         alu_operation,
   input  logic [DATA_W-1:0]  alu_out,
   input  logic               alu_zero,
   input  logic               alu_sign,
   output logic [1:0]         flags_q,
   output logic               branch_taken,
   output logic [DATA_W-1:0]  branch_offset,
   output logic               illegal,
   output logic               done
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_WB, S_ILL} state_t;

   localparam logic [1:0] CLS_RR  = 2'b00;
   localparam logic [1:0] CLS_RI  = 2'b01;
   localparam logic [1:0] CLS_BR  = 2'b10;
   localparam logic [3:0] OP_LTZ  = 4'd7;
   localparam logic [3:0] OP_EQZ  = 4'd8;
   localparam logic [3:0] OP_SUB  = 4'd10;
   localparam logic [3:0] OP_IDLE = 4'b1111;

   state_t state, nstate;

   logic [1:0]               cls_p0;
   logic [3:0]               op_p0;
   logic [RADDR_W-1:0]       rs_p0;
   logic [15:0]              imm_p0;
   logic signed [DATA_W-1:0] res_p2;
   logic                     zero_p2;
   logic                     sign_p2;
   logic                     accept;

   function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] imm);
      return {{(DATA_W-16){imm[15]}}, imm};
   endfunction

   function automatic logic is_legal(input logic [31:0] w);
      logic [1:0] cls;
      logic [3:0] op;
      cls = w[31:30];
      op  = w[29:26];
      if (cls == 2'b11 || op > 4'd11)
         return 1'b0;
      if (cls == CLS_BR)
         return (op == OP_LTZ) || (op == OP_EQZ);
      return 1'b1;
   endfunction

   assign accept = (state == S_IDLE) && instr_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         S_IDLE:  if (accept) nstate = is_legal(instr) ? S_RD : S_ILL;
         S_RD:    nstate = S_EX;
         S_EX:    nstate = S_WB;
         S_WB:    nstate = S_IDLE;
         S_ILL:   nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   // Read addresses are registered at accept so RF data lands during EX; flags commit at end of WB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_raddr1 <= '0;
         rf_raddr2 <= '0;
         flags_q   <= 2'b00;
      end else begin
         if (accept) begin
            rf_raddr1 <= instr[25:21];
            rf_raddr2 <= instr[20:16];
         end
         if (state == S_WB && op_p0 != OP_SUB)
            flags_q <= {zero_p2, sign_p2};
      end
   end

   // stage p0: decoded fields latched at accept
   always_ff @(posedge clk) begin
      if (accept) begin
         cls_p0 <= instr[31:30];
         op_p0  <= instr[29:26];
         rs_p0  <= instr[25:21];
         imm_p0 <= instr[15:0];
      end
   end

   // stage p2: ALU result and flags captured at the end of EX
   always_ff @(posedge clk) begin
      if (state == S_EX) begin
         res_p2  <= alu_out;
         zero_p2 <= alu_zero;
         sign_p2 <= alu_sign;
      end
   end

   always_comb begin
      instr_ready   = 1'b0;
      rf_we         = 1'b0;
      rf_waddr      = '0;
      rf_wdata      = '0;
      alu_inp1      = '0;
      alu_inp2      = '0;
      alu_operation = OP_IDLE;
      branch_taken  = 1'b0;
      branch_offset = '0;
      illegal       = 1'b0;
      done          = 1'b0;
      case (state)
         S_IDLE: instr_ready = 1'b1;
         S_EX: begin
            alu_inp1      = rf_rdata1;
            alu_inp2      = (cls_p0 == CLS_RI) ? sext16(imm_p0) : rf_rdata2;
            alu_operation = op_p0;
         end
         S_WB: begin
            done     = 1'b1;
            rf_we    = (cls_p0 == CLS_RR || cls_p0 == CLS_RI) && (rs_p0 != '0);
            rf_waddr = rs_p0;
            rf_wdata = res_p2;
            if (cls_p0 == CLS_BR) begin
               branch_taken  = (op_p0 == OP_LTZ) ? sign_p2 : zero_p2;
               branch_offset = branch_taken ? sext16(imm_p0) : '0;
            end
         end
         S_ILL: begin
            illegal = 1'b1;
            done    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench for alu_issue_sequencer with a behavioural register file and ALU.
module tb_alu_issue_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
   logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
   logic        rf_we;
   logic [31:0] alu_inp1, alu_inp2, alu_out;
   logic [3:0]  alu_operation;
   logic        alu_zero, alu_sign;
   logic [1:0]  flags_q;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        illegal, done;

   alu_issue_sequencer #(.DATA_W(32), .RADDR_W(5)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_operation(alu_operation),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_sign(alu_sign),
      .flags_q(flags_q), .branch_taken(branch_taken), .branch_offset(branch_offset),
      .illegal(illegal), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        legal;
      logic [3:0]  op;
      int          lat;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        ill;
      logic        taken;
      logic [31:0] off;
      logic [1:0]  flags;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] rf  [32];
   logic [31:0] mdl [32];
   logic [1:0]  flags_m = 2'b00;
   int          n_chk = 0, n_pass = 0;
   int          cyc = 0, acc_cyc = 0, n_acc = 0;
   bit          mon_en = 0;
   bit          flag_pend = 0;
   logic [1:0]  flag_exp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_chk++;
      if (obs === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, req);
   endtask

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a & b;
         4'd2:  return a ^ b;
         4'd3:  return {31'b0, $signed(a) < $signed(b)};
         4'd4:  return a << b[4:0];
         4'd5:  return a >> b[4:0];
         4'd6:  return $unsigned($signed(a) >>> b[4:0]);
         4'd7, 4'd8: return a;
         4'd9:  return a | b;
         4'd10: return a - b;
         4'd11: return ~a;
         default: return 32'h0;
      endcase
   endfunction

   assign alu_out  = alu_f(alu_operation, alu_inp1, alu_inp2);
   assign alu_zero = (alu_out == 32'h0);
   assign alu_sign = alu_out[31];

   function automatic logic [31:0] mk(input logic [1:0] c, input logic [3:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
      return {c, op, rs, rt, imm};
   endfunction

   function automatic exp_t predict(input logic [31:0] w);
      exp_t        e;
      logic [1:0]  c;
      logic [31:0] a, b, r, sx;
      c  = w[31:30];
      sx = {{16{w[15]}}, w[15:0]};
      e.op    = w[29:26];
      e.legal = (c != 2'b11) && (w[29:26] < 4'd12) && (c != 2'b10 || w[29:26] == 4'd7 || w[29:26] == 4'd8);
      e.we = 0; e.waddr = w[25:21]; e.wdata = 0; e.taken = 0; e.off = 0;
      e.ill = !e.legal;
      e.lat = e.legal ? 2 : 0;
      if (e.legal) begin
         a = mdl[w[25:21]];
         b = (c == 2'b01) ? sx : mdl[w[20:16]];
         r = alu_f(w[29:26], a, b);
         e.wdata = r;
         e.we = (c != 2'b10) && (w[25:21] != 5'd0);
         if (e.we) mdl[w[25:21]] = r;
         if (w[29:26] != 4'd10) flags_m = {r == 32'h0, r[31]};
         if (c == 2'b10) begin
            e.taken = (w[29:26] == 4'd7) ? r[31] : (r == 32'h0);
            e.off   = e.taken ? sx : 32'h0;
         end
      end
      e.flags = flags_m;
      return e;
   endfunction

   // behavioural synchronous register file
   initial forever begin
      @(posedge clk);
      rf_rdata1 <= rf[rf_raddr1];
      rf_rdata2 <= rf[rf_raddr2];
      if (rf_we) rf[rf_waddr] <= rf_wdata;
   end

   // accept detection pushes the expected retirement
   initial forever begin
      @(posedge clk);
      cyc++;
      if (!reset && instr_valid && instr_ready) begin
         sb.push_back(predict(instr));
         acc_cyc = cyc;
         n_acc++;
      end
   end

   // output monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (mon_en) begin
         if (flag_pend) begin
            check("flags_q", flags_q, flag_exp);
            flag_pend = 0;
         end
         if (sb.size() > 0 && sb[0].legal && cyc - acc_cyc == 1)
            check("alu_op_ex", alu_operation, sb[0].op);
         else
            check("alu_op_idle", alu_operation, 4'hF);
         if (done) begin
            if (sb.size() == 0) begin
               check("done_unexpected", done, 0);
            end else begin
               e = sb.pop_front();
               check("latency", cyc - acc_cyc, e.lat);
               check("rf_we", rf_we, e.we);
               if (e.we) begin
                  check("rf_waddr", rf_waddr, e.waddr);
                  check("rf_wdata", rf_wdata, e.wdata);
               end
               check("illegal", illegal, e.ill);
               check("branch_taken", branch_taken, e.taken);
               check("branch_offset", branch_offset, e.off);
               flag_pend = 1;
               flag_exp  = e.flags;
            end
         end else begin
            check("rf_we_quiet", rf_we, 0);
            check("illegal_quiet", illegal, 0);
         end
      end
   end

   task automatic preload(input int idx, input logic [31:0] v);
      rf[idx]  = v;
      mdl[idx] = v;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic issue(input logic [31:0] w);
      int t = 0;
      @(negedge clk);
      while (!instr_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!instr_ready) check("ready_timeout", instr_ready, 1);
      instr       = w;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      drain();
   endtask

   initial begin
      int n0;
      for (int i = 0; i < 32; i++) preload(i, 32'h0);
      reset = 1'b1; instr_valid = 1'b0; instr = 32'h0;
      #12;
      check("rst_ready", instr_ready, 1);
      check("rst_aluop", alu_operation, 4'hF);
      check("rst_done", done, 0);
      check("rst_we", rf_we, 0);
      check("rst_flags", flags_q, 0);
      @(negedge clk); reset = 1'b0; mon_en = 1;

      preload(1, 32'd5); preload(2, 32'd7); preload(3, 32'h0000_00FF);
      preload(4, 32'h0);  preload(5, 32'h0); preload(7, 32'h0); preload(8, 32'h0);
      issue(mk(2'b00, 4'd0, 5'd1, 5'd2, 16'h0));        // add R1 = 5 + 7
      check("r1_after_add", rf[1], 32'd12);
      issue(mk(2'b01, 4'd1, 5'd3, 5'd0, 16'hFFF0));     // and imm
      issue(mk(2'b01, 4'd2, 5'd4, 5'd0, 16'h8000));     // xor imm -> sign
      issue(mk(2'b10, 4'd8, 5'd5, 5'd0, 16'hFFFC));     // eqz taken
      preload(5, 32'd3);
      issue(mk(2'b10, 4'd8, 5'd5, 5'd0, 16'hFFFC));     // eqz not taken
      issue(mk(2'b11, 4'd0, 5'd1, 5'd2, 16'h0));        // class 11
      issue(mk(2'b00, 4'd13, 5'd1, 5'd2, 16'h0));       // op 13
      issue(mk(2'b10, 4'd0, 5'd1, 5'd2, 16'h0));        // branch with add
      issue(mk(2'b00, 4'd0, 5'd7, 5'd8, 16'h0));        // add -> zero
      issue(mk(2'b00, 4'd10, 5'd2, 5'd1, 16'h0));       // sub keeps flags
      issue(mk(2'b00, 4'd0, 5'd0, 5'd1, 16'h0));        // dest R0
      issue(mk(2'b10, 4'd7, 5'd4, 5'd0, 16'h0010));     // ltz taken

      // asynchronous reset during EX discards the instruction
      @(negedge clk);
      instr = mk(2'b00, 4'd0, 5'd0, 5'd1, 16'h0); instr_valid = 1'b1;
      @(negedge clk); instr_valid = 1'b0;
      @(negedge clk);
      check("ex_aluop", alu_operation, 4'd0);
      mon_en = 0; flag_pend = 0;
      #1 reset = 1'b1;
      #1;
      check("rst_ex_ready", instr_ready, 1);
      check("rst_ex_aluop", alu_operation, 4'hF);
      check("rst_ex_we", rf_we, 0);
      check("rst_ex_done", done, 0);
      check("rst_ex_flags", flags_q, 0);
      check("rst_ex_raddr2", rf_raddr2, 0);
      sb.delete(); flags_m = 2'b00;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1 check("no_wb_after_rst", done, 0);
      @(negedge clk); mon_en = 1;

      // valid held high: one accept every four cycles
      preload(6, 32'd100);
      instr = mk(2'b01, 4'd0, 5'd6, 5'd0, 16'd1); instr_valid = 1'b1;
      n0 = n_acc;
      repeat (16) @(negedge clk);
      instr_valid = 1'b0;
      check("accepts_in_16", n_acc - n0, 4);
      drain();

      for (int k = 0; k < 8; k++)
         issue(mk(2'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 16'($urandom)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
